// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Owns the program counter, drives the
//               instruction-memory read port, re-aligns the 1-cycle registered
//               read data with its PC, and offers a valid/stall handshake to
//               decode. Handles execute redirects and halts on ECALL.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_rd,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  input  logic        i_stall,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic        o_halted
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALLED = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_resp_pc;
  logic        r_resp_valid;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic        r_hold_valid;

  logic        w_redirect;
  logic [31:0] w_redirect_tgt;
  logic        w_issue;
  logic        w_capture;
  logic        w_release;
  logic        w_accept;
  logic        w_is_ecall;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;

  // Redirects are ignored once halted; target is forced word aligned.
  assign w_redirect     = i_redirect_en && (r_state != ST_HALTED);
  assign w_redirect_tgt = i_redirect_pc & ~32'd3;

  // Presented instruction: the captured copy while stalled, otherwise the
  // live memory data aligned with the PC that requested it.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_instr = 32'd0;
    w_out_pc    = r_resp_pc;
    if (r_hold_valid) begin
      w_out_valid = 1'b1;
      w_out_instr = r_hold_instr;
      w_out_pc    = r_hold_pc;
    end else if (r_resp_valid) begin
      w_out_valid = 1'b1;
      w_out_instr = i_imem_instr;
    end
    if (r_state == ST_HALTED) begin
      w_out_valid = 1'b0;
    end
  end

  // A redirect squashes whatever is presented, so it is never accepted.
  assign w_accept   = w_out_valid && !i_stall && !w_redirect;
  assign w_is_ecall = (w_out_instr[6:0] == 7'b1110011) &&
                      (w_out_instr[14:12] == 3'b000) &&
                      (w_out_instr[31:20] == 12'd0);

  // Next-state and fetch-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_redirect) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (!i_stall) begin
          w_issue = 1'b1;
          if (w_accept && w_is_ecall) begin
            w_state_nxt = ST_HALTED;
          end
        end else if (w_out_valid) begin
          // Memory data will not stay put once fetch moves on, so the
          // presented word must be captured before stalling.
          w_capture   = 1'b1;
          w_state_nxt = ST_STALLED;
        end
      end
      ST_STALLED: begin
        if (w_redirect) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (!i_stall) begin
          w_issue     = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = w_is_ecall ? ST_HALTED : ST_RUN;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program counter: follows redirects, otherwise steps on every issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_fetch_pc <= (w_redirect_tgt + PC_STEP) & ~32'd3;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  // Response tracker: remembers which PC the memory is returning data for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_pc    <= 32'd0;
    end else if (w_issue) begin
      r_resp_valid <= 1'b1;
      r_resp_pc    <= w_redirect ? w_redirect_tgt : r_fetch_pc;
    end
  end

  // Hold buffer for the instruction presented when decode stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_instr <= 32'd0;
      r_hold_pc    <= 32'd0;
    end else if (w_redirect) begin
      r_hold_valid <= 1'b0;
    end else if (w_capture) begin
      r_hold_valid <= 1'b1;
      r_hold_instr <= i_imem_instr;
      r_hold_pc    <= r_resp_pc;
    end else if (w_release) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Read enable is suppressed while reset is asserted so the memory sees no
  // request until the first cycle after release.
  assign o_imem_rd   = w_issue && rst_n;
  assign o_imem_addr = w_redirect ? w_redirect_tgt : r_fetch_pc;
  assign o_if_valid  = w_out_valid;
  assign o_if_instr  = w_out_instr;
  assign o_if_pc     = w_out_pc;
  assign o_halted    = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed vector table,
//               hand-written corner sequences and randomized episodes checked
//               against a behavioural model of the instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] C_BASE  = 32'h0100_0000;
  localparam logic [31:0] C_NOP   = 32'h0000_0013;
  localparam logic [31:0] C_ECALL = 32'h0000_0073;

  logic        clk;
  logic        rst_n;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;

  int checks;
  int errors;

  logic [31:0] mem [0:1023];
  logic        oor_nop;

  instr_fetch #(
    .RESET_PC (C_BASE),
    .PC_STEP  (32'd4)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_rd     (imem_rd),
    .o_imem_addr   (imem_addr),
    .i_imem_instr  (imem_instr),
    .i_stall       (stall),
    .i_redirect_en (redirect_en),
    .i_redirect_pc (redirect_pc),
    .o_if_valid    (if_valid),
    .o_if_instr    (if_instr),
    .o_if_pc       (if_pc),
    .o_halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at a byte address; out-of-range returns ECALL unless the
  // episode asks for NOPs there instead.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - C_BASE;
    if (off < 32'd4096) return mem[off[11:2]];
    return oor_nop ? C_NOP : C_ECALL;
  endfunction

  // Registered-read instruction memory.
  always @(posedge clk) begin
    if (imem_rd) imem_instr <= mem_word(imem_addr);
  end
  initial imem_instr = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Holds reset for two cycles, checks reset outputs, releases at a negedge.
  task automatic do_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rd",     32'(imem_rd),  32'd0);
    chk("rst_addr",   imem_addr,     C_BASE);
    chk("rst_valid",  32'(if_valid), 32'd0);
    chk("rst_instr",  if_instr,      32'd0);
    chk("rst_pc",     if_pc,         32'd0);
    chk("rst_halted", 32'(halted),   32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rd;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halted;
  } vec_t;

  vec_t vecs [16];

  // Behavioural model state: the instruction being presented to decode.
  logic        m_valid;
  logic [31:0] m_cur;
  logic        m_halted;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    // ---------------- directed vector table ----------------
    //                stall redir rpc           rd  addr            valid pc              instr    halted
    vecs[0]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'h0100_0000, 1'b0, 32'd0,         C_NOP,   1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'h0100_0004, 1'b1, 32'h0100_0000, C_NOP,   1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'h0100_0008, 1'b1, 32'h0100_0004, C_NOP,   1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd0,         1'b0, 32'h0100_000C, 1'b1, 32'h0100_0008, C_NOP,   1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'd0,         1'b0, 32'h0100_000C, 1'b1, 32'h0100_0008, C_NOP,   1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'd0,         1'b0, 32'h0100_000C, 1'b1, 32'h0100_0008, C_NOP,   1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'h0100_000C, 1'b1, 32'h0100_0008, C_NOP,   1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'd0,         1'b0, 32'h0100_0010, 1'b1, 32'h0100_000C, C_NOP,   1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0100_0102, 1'b1, 32'h0100_0100, 1'b1, 32'h0100_000C, C_NOP,   1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'h0100_0104, 1'b1, 32'h0100_0100, C_NOP,   1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'd0,         1'b1, 32'h0100_0108, 1'b1, 32'h0100_0104, C_NOP,   1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0100_0010, 1'b1, 32'h0100_0010, 1'b1, 32'h0100_0108, C_NOP,   1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'd0,         1'b1, 32'h0100_0014, 1'b1, 32'h0100_0010, C_ECALL, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'd0,         1'b0, 32'h0100_0018, 1'b0, 32'd0,         C_NOP,   1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'h0100_0000, 1'b0, 32'h0100_0018, 1'b0, 32'd0,         C_NOP,   1'b1};
    vecs[15] = '{1'b1, 1'b0, 32'd0,         1'b0, 32'h0100_0018, 1'b0, 32'd0,         C_NOP,   1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = C_NOP;
    mem[4]  = C_ECALL;
    oor_nop = 1'b0;

    do_reset();
    for (int i = 0; i < 16; i++) begin
      stall       = vecs[i].stall;
      redirect_en = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_rd", i),     32'(imem_rd),  32'(vecs[i].rd));
      chk($sformatf("v%0d_addr", i),   imem_addr,     vecs[i].addr);
      chk($sformatf("v%0d_valid", i),  32'(if_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_halted", i), 32'(halted),   32'(vecs[i].halted));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_pc", i),    if_pc,    vecs[i].pc);
        chk($sformatf("v%0d_instr", i), if_instr, vecs[i].instr);
      end
      @(negedge clk);
    end

    // ---------------- out-of-range redirect halts ----------------
    do_reset();
    #1;
    chk("oor_c0_rd", 32'(imem_rd), 32'd1);
    @(negedge clk);
    redirect_en = 1'b1;
    redirect_pc = 32'h0100_1000;
    #1;
    chk("oor_c1_addr", imem_addr,   32'h0100_1000);
    chk("oor_c1_rd",   32'(imem_rd), 32'd1);
    @(negedge clk);
    redirect_en = 1'b0;
    #1;
    chk("oor_c2_valid",  32'(if_valid), 32'd1);
    chk("oor_c2_pc",     if_pc,         32'h0100_1000);
    chk("oor_c2_instr",  if_instr,      C_ECALL);
    chk("oor_c2_halted", 32'(halted),   32'd0);
    @(negedge clk);
    #1;
    chk("oor_c3_halted", 32'(halted),   32'd1);
    chk("oor_c3_valid",  32'(if_valid), 32'd0);
    chk("oor_c3_rd",     32'(imem_rd),  32'd0);
    @(negedge clk);

    // ---------------- reset asserted mid-stall ----------------
    do_reset();
    repeat (3) @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("ms_stalled_valid", 32'(if_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ms_rst_rd",     32'(imem_rd),  32'd0);
    chk("ms_rst_addr",   imem_addr,     C_BASE);
    chk("ms_rst_valid",  32'(if_valid), 32'd0);
    chk("ms_rst_pc",     if_pc,         32'd0);
    chk("ms_rst_instr",  if_instr,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    #1;
    chk("ms_rel_rd",   32'(imem_rd), 32'd1);
    chk("ms_rel_addr", imem_addr,    C_BASE);
    @(negedge clk);
    #1;
    chk("ms_rel_valid", 32'(if_valid), 32'd1);
    chk("ms_rel_pc",    if_pc,         C_BASE);
    @(negedge clk);

    // ---------------- randomized episodes vs. model ----------------
    for (int ep = 0; ep < 4; ep++) begin
      for (int i = 0; i < 1024; i++) begin
        logic [31:0] w;
        w = $urandom;
        if (w[6:0] == 7'b1110011) w = C_NOP;
        if ($urandom_range(0, 199) == 0) w = C_ECALL;
        mem[i] = w;
      end
      oor_nop = 1'b1;
      do_reset();
      m_valid  = 1'b0;
      m_cur    = C_BASE;
      m_halted = 1'b0;
      for (int c = 0; c < 400; c++) begin
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] tgt;
        logic        e_rd;
        logic [31:0] e_addr;
        st  = ($urandom_range(0, 3) == 0);
        rd  = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 4) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else                           rpc = C_BASE + 32'($urandom_range(0, 4095));
        stall       = st;
        redirect_en = rd;
        redirect_pc = rpc;
        tgt = {rpc[31:2], 2'b00};
        #1;
        e_rd   = !m_halted && (rd || !st);
        e_addr = rd ? tgt : (m_valid ? m_cur + 32'd4 : m_cur);
        chk("rnd_rd",     32'(imem_rd),  32'(e_rd));
        if (e_rd) chk("rnd_addr", imem_addr, e_addr);
        chk("rnd_valid",  32'(if_valid), 32'(m_valid && !m_halted));
        chk("rnd_halted", 32'(halted),   32'(m_halted));
        if (m_valid && !m_halted) begin
          chk("rnd_pc",    if_pc,    m_cur);
          chk("rnd_instr", if_instr, mem_word(m_cur));
        end
        // Advance the model by one cycle.
        if (!m_halted) begin
          if (rd) begin
            m_cur   = tgt;
            m_valid = 1'b1;
          end else if (!st) begin
            if (m_valid) begin
              if (mem_word(m_cur) == C_ECALL) begin
                m_halted = 1'b1;
                m_valid  = 1'b0;
              end else begin
                m_cur = m_cur + 32'd4;
              end
            end else begin
              m_valid = 1'b1;
            end
          end
        end
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
